// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
//   Lets NREQ flit sources share one external combinational N-bit adder.
//   A source that wins round-robin arbitration keeps the adder until the
//   last flit of its packet is accepted. Each accepted flit's sum is
//   registered and returned with the owner ID.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_last [NREQ]      per-source flit valid / last-of-packet
//   req_a/req_b [NREQ*N]           per-source operands, source i at [i*N +: N]
//   req_ready [NREQ]               per-source accept (one-hot or zero)
//   input1/input2 [N]              operands to the adder (owner's a/b, 0 when idle)
//   sum [N]                        adder result (input1+input2, carry dropped)
//   rsp_valid/rsp_ready            registered response handshake
//   rsp_sum [N], rsp_id [IDW]      registered sum and its owner
//   rsp_last                       response belongs to the packet's last flit
//   flit_cnt [32]                  accepted flits, saturating
//
// state | meaning
// IDLE  | no owner; pick the first valid source at or after rr_ptr
// LOCK  | owner streams flits until its last flit is accepted
module adder_rr_scheduler #(
  parameter int N    = 18,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      input1,
  output logic [N-1:0]      input2,
  input  logic [N-1:0]      sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_last,
  output logic [31:0]       flit_cnt
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]  own_idx;
  logic           slot_free;
  logic           accept;
  logic           found;
  int             idx;

  assign own_idx = owner[PW-1:0];

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    req_ready  = '0;
    input1     = '0;
    input2     = '0;
    accept     = 1'b0;
    found      = 1'b0;
    idx        = 0;
    // A new flit may enter only if the response slot is empty or draining now.
    slot_free  = !rsp_valid || rsp_ready;
    case (state)
      IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          idx = int'(rr_ptr) + i;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && req_valid[idx[PW-1:0]]) begin
            found     = 1'b1;
            owner_nxt = IDW'(idx);
          end
        end
        if (found) state_nxt = LOCK;
      end
      LOCK: begin
        req_ready[own_idx] = slot_free;
        input1 = req_a[own_idx*N +: N];
        input2 = req_b[own_idx*N +: N];
        accept = req_valid[own_idx] && slot_free;
        if (accept && req_last[own_idx]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (int'(owner) == NREQ-1) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
      flit_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (accept) begin
        // Overwrites a response being consumed this same edge.
        rsp_valid <= 1'b1;
        rsp_sum   <= sum;
        rsp_id    <= owner;
        rsp_last  <= req_last[own_idx];
        if (flit_cnt != 32'hFFFF_FFFF) flit_cnt <= flit_cnt + 32'd1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
